// File: rtl/uart_pkg.sv
// Shared UART definitions: rx state encoding, frame defaults and bit-period limits.
package uart_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StStop,
    StWaitIdle
  } rx_state_e;

  localparam int unsigned DATA_BITS_DEFAULT = 8;

  // Smallest usable bit period; the transmitter applies the same floor.
  localparam logic [15:0] CLOCK_DIV_MIN = 16'd4;

  function automatic logic [15:0] clamp_div(input logic [15:0] div);
    return (div < CLOCK_DIV_MIN) ? CLOCK_DIV_MIN : div;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// N-flop synchronizer for an asynchronous serial line; flops reset to the idle (high) level.
module uart_rx_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d};
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: LSB-first frames, one-cycle valid/error strobes.
// Define UART_RX_MAJORITY_EN for 2-of-3 majority sampling around each mid-bit point.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned DATA_BITS   = DATA_BITS_DEFAULT
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [15:0]          clock_div,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 rx_error,
  output logic                 rx_busy
);

  localparam int unsigned IdxW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

`ifdef UART_RX_MAJORITY_EN
  localparam logic [15:0] SampleDelay = 16'd1;
`else
  localparam logic [15:0] SampleDelay = 16'd0;
`endif

  rx_state_e            state_q, state_d;
  logic [15:0]          cnt_q, cnt_d;
  logic [15:0]          div_q, div_d;
  logic [IdxW-1:0]      idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 error_q, error_d;
  logic [SYNC_STAGES-1:0] prime_q;
  logic                 prev_q;
  logic                 rxs;
  logic                 sample;
  logic                 start_edge;
  logic                 tick;

  uart_rx_sync #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clock(clock),
    .reset(reset),
    .d    (rx),
    .q    (rxs)
  );

`ifdef UART_RX_MAJORITY_EN
  logic h1_q, h2_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      h1_q <= 1'b1;
      h2_q <= 1'b1;
    end else begin
      h1_q <= rxs;
      h2_q <= h1_q;
    end
  end

  assign sample = (rxs & h1_q) | (rxs & h2_q) | (h1_q & h2_q);
`else
  assign sample = rxs;
`endif

  // prev_q only goes high on a real line sample, so a line held low out of reset is no edge.
  assign start_edge = prev_q & ~rxs;
  assign tick       = (cnt_q == 16'd0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = 1'b0;
    error_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start_edge) begin
          state_d = StStart;
          div_d   = clamp_div(clock_div);
          cnt_d   = (div_d >> 1) - 16'd1 + SampleDelay;
        end
      end
      StStart: begin
        if (tick) begin
          if (sample) begin
            state_d = StIdle;
          end else begin
            state_d = StData;
            idx_d   = '0;
            cnt_d   = div_q - 16'd1;
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      StData: begin
        if (tick) begin
          shift_d[idx_q] = sample;
          cnt_d          = div_q - 16'd1;
          if (idx_q == IdxW'(DATA_BITS - 1)) begin
            state_d = StStop;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      StStop: begin
        if (tick) begin
          if (sample) begin
            data_d  = shift_q;
            valid_d = 1'b1;
            state_d = StIdle;
          end else begin
            error_d = 1'b1;
            state_d = StWaitIdle;
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      StWaitIdle: begin
        if (rxs) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      div_q   <= CLOCK_DIV_MIN;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      error_q <= 1'b0;
      prime_q <= '0;
      prev_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      error_q <= error_d;
      prime_q <= {prime_q[SYNC_STAGES-2:0], 1'b1};
      prev_q  <= rxs & prime_q[SYNC_STAGES-1];
    end
  end

  assign rx_data  = data_q;
  assign rx_valid = valid_q;
  assign rx_error = error_q;
  assign rx_busy  = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx.sv
// Randomized bench for uart_rx: frames are driven cycle by cycle and the received
// byte/error stream is compared against a frame-level expectation queue.
module tb_uart_rx;

  localparam int SyncStages = 2;
`ifdef UART_RX_MAJORITY_EN
  localparam int MajDelay = 1;
`else
  localparam int MajDelay = 0;
`endif
  localparam int ErrEvt = 256;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] clock_div = 16'd217;
  logic        rx = 1'b0;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_error;
  logic        rx_busy;

  always #5 clock = ~clock;

  uart_rx #(
    .SYNC_STAGES(SyncStages),
    .DATA_BITS  (8)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .clock_div(clock_div),
    .rx       (rx),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_error (rx_error),
    .rx_busy  (rx_busy)
  );

  int n_total = 0;
  int n_bad   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Monitor: record strobes away from the active edge.
  int   cyc = 0;
  int   got_q[$];
  int   last_evt_cyc = 0;
  logic both_seen = 1'b0;
  logic long_pulse = 1'b0;
  logic prev_valid = 1'b0;
  logic prev_err = 1'b0;

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (!reset) begin
      if (rx_valid) begin
        got_q.push_back(int'(rx_data));
        last_evt_cyc = cyc;
      end
      if (rx_error) got_q.push_back(ErrEvt);
      if (rx_valid && rx_error) both_seen = 1'b1;
      if ((rx_valid && prev_valid) || (rx_error && prev_err)) long_pulse = 1'b1;
    end
    prev_valid = rx_valid;
    prev_err   = rx_error;
  end

  // Reference: a good frame yields its byte, a low stop bit yields one error event.
  int         exp_q[$];
  logic [7:0] last_good = 8'h00;
  int         frame_start = 0;

  function automatic void expect_frame(input logic [7:0] b, input bit stop_ok);
    if (stop_ok) begin
      exp_q.push_back(int'(b));
      last_good = b;
    end else begin
      exp_q.push_back(ErrEvt);
    end
  endfunction

  task automatic check_events(input string tag);
    int n;
    check_eq({tag, "_count"}, got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check_eq($sformatf("%s_evt%0d", tag, i), got_q[i], exp_q[i]);
    end
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clock);
  endtask

  task automatic hold_low(input int n);
    rx = 1'b0;
    repeat (n) @(negedge clock);
  endtask

  // Drives one frame; glitch_at inverts a single cycle, reset_at aborts the frame with a reset.
  task automatic send_frame(input logic [7:0] b, input int div_prog, input bit stop_ok,
                            input int glitch_at, input int reset_at, input bit scramble);
    int         d;
    logic [9:0] bits;
    d    = (div_prog < 4) ? 4 : div_prog;
    bits = {stop_ok, b, 1'b0};
    for (int c = 0; c < 10 * d; c++) begin
      @(negedge clock);
      if (c == 0) begin
        clock_div   = 16'(div_prog);
        frame_start = cyc;
      end
      if (scramble && c == 4) clock_div = 16'($urandom_range(1, 300));
      if (c == reset_at) begin
        reset = 1'b1;
        rx    = 1'b1;
        @(negedge clock);
        check_eq("rst_valid", rx_valid, 0);
        check_eq("rst_error", rx_error, 0);
        check_eq("rst_busy", rx_busy, 0);
        check_eq("rst_data", rx_data, 0);
        @(negedge clock);
        reset     = 1'b0;
        last_good = 8'h00;
        return;
      end
      rx = (c == glitch_at) ? ~bits[c/d] : bits[c/d];
    end
  endtask

  initial begin
    // Reset with the line low; a low line out of reset must not start a frame.
    rx    = 1'b0;
    reset = 1'b1;
    repeat (3) @(negedge clock);
    check_eq("reset_valid", rx_valid, 0);
    check_eq("reset_error", rx_error, 0);
    check_eq("reset_busy", rx_busy, 0);
    check_eq("reset_data", rx_data, 0);
    reset = 1'b0;
    repeat (30) @(negedge clock);
    check_eq("low_after_reset_busy", rx_busy, 0);
    idle(20);

    // Single frame, plus end-to-end latency.
    expect_frame(8'h41, 1'b1);
    send_frame(8'h41, 217, 1'b1, -1, -1, 1'b0);
    idle(2 * 217);
    check_events("t1");
    check_eq("t1_latency", last_evt_cyc - frame_start,
             9 * 217 + 217 / 2 + SyncStages + 1 + MajDelay);

    // Back-to-back frames with no idle gap.
    expect_frame(8'h44, 1'b1);
    expect_frame(8'h41, 1'b1);
    expect_frame(8'h4D, 1'b1);
    send_frame(8'h44, 217, 1'b1, -1, -1, 1'b0);
    send_frame(8'h41, 217, 1'b1, -1, -1, 1'b0);
    send_frame(8'h4D, 217, 1'b1, -1, -1, 1'b0);
    idle(2 * 217);
    check_events("t2");

    // Short low pulse: start aborted at mid-bit.
    clock_div = 16'd217;
    hold_low(40);
    check_eq("t3_busy_during", rx_busy, 1);
    hold_low(10);
    idle(400);
    check_events("t3");
    check_eq("t3_busy_after", rx_busy, 0);
    check_eq("t3_data_kept", rx_data, last_good);

    // Framing error followed by a break, then a clean frame.
    expect_frame(8'h55, 1'b0);
    send_frame(8'h55, 217, 1'b0, -1, -1, 1'b0);
    hold_low(3 * 217);
    idle(217);
    check_eq("t4_data_kept", rx_data, last_good);
    expect_frame(8'h3C, 1'b1);
    send_frame(8'h3C, 217, 1'b1, -1, -1, 1'b0);
    idle(2 * 217);
    check_events("t4");

    // Reset in data bit 4 of 0x7E, then a clean 0x81.
    send_frame(8'h7E, 217, 1'b1, -1, 5 * 217 + 100, 1'b0);
    idle(3 * 217);
    check_eq("t5_data_cleared", rx_data, 0);
    expect_frame(8'h81, 1'b1);
    send_frame(8'h81, 217, 1'b1, -1, -1, 1'b0);
    idle(2 * 217);
    check_events("t5");

    // One-cycle high glitch exactly at the mid-point of data bit 3.
`ifdef UART_RX_MAJORITY_EN
    expect_frame(8'h00, 1'b1);
`else
    expect_frame(8'h08, 1'b1);
`endif
    send_frame(8'h00, 217, 1'b1, 4 * 217 + 217 / 2, -1, 1'b0);
    idle(2 * 217);
    check_events("t6");

    // Random frames: random divisors (including clamped ones), gaps, framing errors,
    // and clock_div scrambled mid-frame.
    for (int i = 0; i < 20; i++) begin
      logic [7:0] b;
      int         dp;
      int         d;
      bit         ok;
      b  = 8'($urandom);
      dp = $urandom_range(1, 24);
      d  = (dp < 4) ? 4 : dp;
      ok = ($urandom_range(0, 4) != 0);
      expect_frame(b, ok);
      send_frame(b, dp, ok, -1, -1, 1'b1);
      if (!ok) begin
        hold_low($urandom_range(0, 3 * d));
        idle(d + $urandom_range(0, d));
      end else begin
        idle($urandom_range(0, 2 * d));
      end
    end
    idle(100);
    check_events("rand");

    check_eq("valid_error_overlap", both_seen, 0);
    check_eq("strobe_width", long_pulse, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
